// File: rtl/glay_cache_req_arbiter_pkg.sv
// Shared request/response packet types and setup-FSM states for the GLay
// cache request arbiter.
package glay_cache_req_arbiter_pkg;

    localparam int ROUTE_ID_W = 8;
    localparam int CMD_W      = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [ROUTE_ID_W-1:0] route_id;
        logic [CMD_W-1:0]      cmd;
    } MemoryPacketMeta;

    typedef struct packed {
        MemoryPacketMeta   meta;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } MemoryRequestPayload;

    typedef struct packed {
        logic                valid;
        MemoryRequestPayload payload;
    } MemoryRequestPacket;

    typedef struct packed {
        MemoryPacketMeta   meta;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } MemoryResponsePayload;

    typedef struct packed {
        logic                 valid;
        MemoryResponsePayload payload;
    } MemoryResponsePacket;

    typedef enum logic [1:0] {
        SETUP_RESET,
        SETUP_WAIT,
        SETUP_READY
    } arbiter_setup_state;

endpackage

// File: rtl/glay_round_robin_arbiter.sv
// Combinational round-robin picker: first valid source at or after ptr,
// returned as a one-hot grant plus its index.
module glay_round_robin_arbiter #(
    parameter int NUM      = 2,
    parameter int ID_WIDTH = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0]      valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM-1:0]      grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_valid
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < NUM; off++) begin
            idx = (32'(ptr) + off) % NUM;
            if (!grant_valid && valid[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/glay_cache_req_arbiter.sv
// Merges per-source memory requests onto one cache port with round-robin
// fairness, stamps the route id, and routes cache responses back by that id.
module glay_cache_req_arbiter
    import glay_cache_req_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTORS = 2,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTORS),
    parameter int SETUP_CYCLES   = 4,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  MemoryRequestPacket        req_in [NUM_REQUESTORS],
    output logic [NUM_REQUESTORS-1:0] req_in_ready,
    output MemoryRequestPacket        req_out,
    input  logic                      req_out_ready,
    input  MemoryResponsePacket       resp_in,
    output MemoryResponsePacket       resp_out [NUM_REQUESTORS],
    output logic [COUNTER_WIDTH-1:0]  grant_count,
    output logic                      route_error,
    output logic                      fifo_setup_signal
);

    localparam int SETUP_CNT_W = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;

    arbiter_setup_state       state_q, state_d;
    logic [SETUP_CNT_W-1:0]   setup_cnt_q, setup_cnt_d;

    logic [ID_WIDTH-1:0]       rr_ptr;
    logic [NUM_REQUESTORS-1:0] req_valid;
    logic [NUM_REQUESTORS-1:0] rr_grant;
    logic [ID_WIDTH-1:0]       rr_idx;
    logic                      rr_any;
    logic                      slot_loadable;
    logic                      do_grant;

    logic                      out_valid_q;
    MemoryRequestPayload       out_payload_q;
    logic [NUM_REQUESTORS-1:0] resp_valid_q;
    MemoryResponsePayload      resp_payload_q;

    // Setup FSM: one cycle leaving reset, then SETUP_CYCLES-1 wait cycles.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q     <= SETUP_RESET;
            setup_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        case (state_q)
            SETUP_RESET: begin
                state_d     = SETUP_WAIT;
                setup_cnt_d = '0;
            end
            SETUP_WAIT: begin
                if (32'(setup_cnt_q) + 32'd2 >= 32'(SETUP_CYCLES))
                    state_d = SETUP_READY;
                else
                    setup_cnt_d = setup_cnt_q + 1'b1;
            end
            SETUP_READY: state_d = SETUP_READY;
            default:     state_d = SETUP_RESET;
        endcase
    end

    assign fifo_setup_signal = (state_q != SETUP_READY);

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQUESTORS; i++)
            req_valid[i] = req_in[i].valid;
    end

    glay_round_robin_arbiter #(
        .NUM      (NUM_REQUESTORS),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .valid       (req_valid),
        .ptr         (rr_ptr),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_any)
    );

    assign slot_loadable = !out_valid_q || req_out_ready;
    assign do_grant      = rr_any && slot_loadable && !fifo_setup_signal;
    assign req_in_ready  = (slot_loadable && !fifo_setup_signal) ? rr_grant : '0;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            rr_ptr      <= '0;
            grant_count <= '0;
        end else if (do_grant) begin
            out_valid_q <= 1'b1;
            rr_ptr      <= (rr_idx == ID_WIDTH'(NUM_REQUESTORS - 1)) ? '0 : rr_idx + 1'b1;
            if (grant_count != '1)
                grant_count <= grant_count + 1'b1;
        end else if (slot_loadable) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (do_grant) begin
            out_payload_q               <= req_in[rr_idx].payload;
            out_payload_q.meta.route_id <= ROUTE_ID_W'(rr_idx);
        end
    end

    assign req_out.valid   = out_valid_q;
    assign req_out.payload = out_payload_q;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            resp_valid_q <= '0;
            route_error  <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQUESTORS; k++)
                resp_valid_q[k] <= resp_in.valid &&
                                   (resp_in.payload.meta.route_id == ROUTE_ID_W'(k));
            if (resp_in.valid &&
                (resp_in.payload.meta.route_id >= ROUTE_ID_W'(NUM_REQUESTORS)))
                route_error <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        resp_payload_q <= resp_in.payload;
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQUESTORS; k++) begin
            resp_out[k].valid   = resp_valid_q[k];
            resp_out[k].payload = resp_payload_q;
        end
    end

endmodule

// File: tb/tb_glay_cache_req_arbiter.sv
// Randomised and directed bench for glay_cache_req_arbiter against a
// cycle-level behavioural model of the arbitration and routing rules.
module tb_glay_cache_req_arbiter;
    import glay_cache_req_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int SC = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                ap_clk = 1'b0;
    logic                areset;
    MemoryRequestPacket  req_in [N];
    logic [N-1:0]        req_in_ready;
    MemoryRequestPacket  req_out;
    logic                req_out_ready;
    MemoryResponsePacket resp_in;
    MemoryResponsePacket resp_out [N];
    logic [CW-1:0]       grant_count;
    logic                route_error;
    logic                fifo_setup_signal;

    glay_cache_req_arbiter #(
        .NUM_REQUESTORS (N),
        .SETUP_CYCLES   (SC),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .ap_clk            (ap_clk),
        .areset            (areset),
        .req_in            (req_in),
        .req_in_ready      (req_in_ready),
        .req_out           (req_out),
        .req_out_ready     (req_out_ready),
        .resp_in           (resp_in),
        .resp_out          (resp_out),
        .grant_count       (grant_count),
        .route_error       (route_error),
        .fifo_setup_signal (fifo_setup_signal)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycles since reset release, pointer, one-entry slot.
    int                   m_since_rel;
    int                   m_ptr;
    bit                   m_slot_v;
    MemoryRequestPayload  m_slot_p;
    int                   m_count;
    bit                   m_err;
    bit [N-1:0]           m_resp_v;
    MemoryResponsePayload m_resp_p;

    task automatic model_reset();
        m_since_rel = 0;
        m_ptr       = 0;
        m_slot_v    = 0;
        m_count     = 0;
        m_err       = 0;
        m_resp_v    = '0;
    endtask

    function automatic int pick();
        if (m_since_rel < SC) return -1;
        if (m_slot_v && !req_out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_in[(m_ptr + k) % N].valid) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        int rid;
        g = pick();
        if (g >= 0) begin
            m_slot_p = req_in[g].payload;
            m_slot_p.meta.route_id = 8'(g);
            m_slot_v = 1;
            m_ptr    = (g + 1) % N;
            m_count  = (m_count < CMAX) ? m_count + 1 : CMAX;
        end else if (!m_slot_v || req_out_ready) begin
            m_slot_v = 0;
        end
        rid = int'(resp_in.payload.meta.route_id);
        for (int k = 0; k < N; k++) m_resp_v[k] = resp_in.valid && (rid == k);
        m_resp_p = resp_in.payload;
        if (resp_in.valid && rid >= N) m_err = 1;
        if (m_since_rel < SC) m_since_rel++;
    endtask

    task automatic check_regs();
        check("req_out.valid", req_out.valid, m_slot_v);
        if (m_slot_v) check("req_out.payload", req_out.payload, m_slot_p);
        check("fifo_setup_signal", fifo_setup_signal, m_since_rel < SC);
        check("grant_count", grant_count, m_count);
        check("route_error", route_error, m_err);
        for (int k = 0; k < N; k++) begin
            check($sformatf("resp_out[%0d].valid", k), resp_out[k].valid, m_resp_v[k]);
            if (m_resp_v[k])
                check($sformatf("resp_out[%0d].payload", k), resp_out[k].payload, m_resp_p);
        end
    endtask

    // One clock: check registered state, drive inputs, check grant, advance model.
    task automatic cycle(input logic [N-1:0] v, input bit rdy, input bit rv, input int rid);
        int g;
        logic [N-1:0] exp_rdy;
        check_regs();
        for (int i = 0; i < N; i++) begin
            req_in[i].valid                 = v[i];
            req_in[i].payload.meta.route_id = 8'($urandom);
            req_in[i].payload.meta.cmd      = 4'($urandom);
            req_in[i].payload.address       = $urandom;
            req_in[i].payload.data          = $urandom;
        end
        req_out_ready                  = rdy;
        resp_in.valid                  = rv;
        resp_in.payload.meta.route_id  = 8'(rid);
        resp_in.payload.meta.cmd       = 4'($urandom);
        resp_in.payload.address        = $urandom;
        resp_in.payload.data           = $urandom;
        #1;
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_in_ready", req_in_ready, exp_rdy);
        model_step();
        @(negedge ap_clk);
    endtask

    initial begin
        areset        = 1'b1;
        req_out_ready = 1'b0;
        resp_in       = '0;
        for (int i = 0; i < N; i++) req_in[i] = '0;
        model_reset();
        repeat (2) @(negedge ap_clk);
        check_regs();
        check("reset req_in_ready", req_in_ready, '0);
        areset = 1'b0;

        // Setup window then alternating grants with both sources valid
        repeat (SC + 8) cycle(2'b11, 1'b1, 1'b0, 0);
        check("grant_count after 8", grant_count, 8);

        // Only source 1 requesting: back-to-back grants to 1
        repeat (5) cycle(2'b10, 1'b1, 1'b0, 0);

        // Backpressure with slot full, then release
        repeat (3) cycle(2'b11, 1'b0, 1'b0, 0);
        repeat (2) cycle(2'b11, 1'b1, 1'b0, 0);

        // Response routing and out-of-range route id
        cycle(2'b00, 1'b1, 1'b1, 1);
        cycle(2'b00, 1'b1, 1'b1, 0);
        cycle(2'b00, 1'b1, 1'b1, 3);
        repeat (3) cycle(2'b00, 1'b1, 1'b0, 0);
        check("route_error sticky", route_error, 1'b1);

        // Drive the counter into saturation
        repeat (CMAX + 2) cycle(2'b11, 1'b1, 1'b0, 0);
        check("grant_count saturated", grant_count, CMAX);

        // Asynchronous reset in the middle of a burst
        #2 areset = 1'b1;
        #1;
        check("mid-reset req_out.valid", req_out.valid, 1'b0);
        check("mid-reset grant_count", grant_count, 0);
        check("mid-reset route_error", route_error, 1'b0);
        check("mid-reset fifo_setup_signal", fifo_setup_signal, 1'b1);
        check("mid-reset req_in_ready", req_in_ready, '0);
        model_reset();
        @(negedge ap_clk);
        areset = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 400; n++)
            cycle(N'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom), $urandom_range(0, 3));
        check_regs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glay_cache_req_arbiter.md
# glay_cache_req_arbiter

Merges memory requests from NUM_REQUESTORS GLay request sources (kernel setup, engines) onto the single cache request port with round-robin fairness. It stamps each granted request with its requester index and routes returning cache responses back to the owning requester by that index. Sits directly downstream of glay_kernel_setup's request-out FIFO and directly upstream of its response-in FIFO.

## Interface
Parameters:
- NUM_REQUESTORS, 2, number of request sources (≥2)
- ID_WIDTH, $clog2(NUM_REQUESTORS), route-id field width used
- SETUP_CYCLES, 4, cycles fifo_setup_signal stays high after reset release
- COUNTER_WIDTH, 32, width of the granted-request counter

Ports:
- ap_clk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- req_in  in  [NUM_REQUESTORS] MemoryRequestPacket  per-source request (valid + payload)
- req_in_ready  out  [NUM_REQUESTORS]  source i transfers when req_in[i].valid && req_in_ready[i]
- req_out  out  MemoryRequestPacket  merged request to cache
- req_out_ready  in  1  cache side can accept (its ~prog_full)
- resp_in  in  MemoryResponsePacket  cache response
- resp_out  out  [NUM_REQUESTORS] MemoryResponsePacket  routed responses
- grant_count  out  COUNTER_WIDTH  total granted requests, saturating
- route_error  out  1  sticky: response with out-of-range route id seen
- fifo_setup_signal  out  1  high while arbiter not ready for traffic

## Operation
- Output slot: one registered request stage (req_out). Slot loadable when !req_out.valid || req_out_ready.
- Grant: combinational round-robin over req_in[i].valid starting at pointer rr_ptr; at most one req_in_ready high, only when slot loadable and fifo_setup_signal low.
- On transfer from i: req_out.payload <= req_in[i].payload with meta.route_id overwritten by i; req_out.valid <= 1; rr_ptr <= (i+1) mod NUM_REQUESTORS (wraps NUM-1 -> 0); grant_count += 1, saturating at all-ones.
- Slot loadable, no request: req_out.valid <= 0. Slot not loadable: req_out held stable.
- rr_ptr unchanged on cycles without grant.
- Response path: resp_out[k].valid <= resp_in.valid && resp_in.payload.meta.route_id == k; payload registered to all outputs unconditionally. No backpressure; consumers absorb every response.
- route_id ≥ NUM_REQUESTORS with resp_in.valid: dropped, route_error <= 1 (sticky until reset).
- Setup FSM: SETUP_RESET (in reset) -> SETUP_WAIT (counter counts SETUP_CYCLES) -> SETUP_READY. fifo_setup_signal = 1 in SETUP_RESET/SETUP_WAIT, 0 in SETUP_READY.

## Timing
- Reset values (asynchronous): all req_in_ready 0, req_out.valid 0, all resp_out[k].valid 0, grant_count 0, route_error 0, fifo_setup_signal 1, rr_ptr 0, FSM SETUP_RESET. Payload registers unreset.
- First grant possible SETUP_CYCLES+1 cycles after areset falls.
- Request latency: 1 cycle from transfer to req_out.valid.
- Response latency: 1 cycle resp_in -> resp_out.
- Throughput: one request per cycle while req_out_ready stays high.
- req_out_ready low with slot full: no req_in_ready asserted; req_out payload/valid stable.
- Simultaneous grant and req_out_ready: old request consumed and new loaded same edge, no bubble.
- Reset mid-operation: in-flight req_out and registered responses discarded immediately; no partial state survives.

## Structure
- Add to GLAY_REQ_PKG: meta.route_id field in MemoryRequestPacket/MemoryResponsePacket meta (width ≥ ID_WIDTH); arbiter_setup_state enum (SETUP_RESET, SETUP_WAIT, SETUP_READY).
- One sub-module: glay_round_robin_arbiter (NUM, valid vector + pointer -> one-hot grant + index, purely combinational); everything else in top.

## Test plan
- NUM=2, both sources valid continuously, req_out_ready=1 -> grants alternate 0,1,0,1; route_id alternates; grant_count=8 after 8 cycles.
- Only source 1 valid for 5 cycles -> 5 back-to-back grants to 1, rr_ptr wraps to 0 each time.
- req_out_ready=0 for 3 cycles with slot full -> req_out unchanged, all req_in_ready 0; on release, held request consumed and next granted same cycle.
- resp_in route_id=1 -> resp_out[1].valid one cycle later, resp_out[0] silent; route_id=3 -> no outputs, route_error=1 persists.
- Deassert areset -> fifo_setup_signal high exactly 4 cycles, first grant at cycle 5; assert areset mid-burst -> req_out.valid 0 immediately, grant_count 0.
- grant_count preloaded near max (COUNTER_WIDTH=4, 15 grants then 2 more) -> holds at 15.
